// File: rtl/router_pkg.sv
// Shared state encodings, port-index constants and sizing helper for the router crossbar.
package router_pkg;

    // Outputs use IDLE/BUSY; inputs use IDLE (header expected), BUSY (routing) and DROP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_e;

    localparam int LOCAL = 0;
    localparam int LEFT  = 1;
    localparam int RIGHT = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/router_xbar_if.sv
// Stream bundle between the crossbar and its neighbours: ingress (s_*) and egress (m_*) per port.
interface router_xbar_if #(
    parameter int NPORTS = 3,
    parameter int DATA_W = 64
);
    logic [NPORTS*DATA_W-1:0] s_tdata;
    logic [NPORTS-1:0]        s_tvalid;
    logic [NPORTS-1:0]        s_tlast;
    logic [NPORTS-1:0]        s_tready;
    logic [NPORTS*DATA_W-1:0] m_tdata;
    logic [NPORTS-1:0]        m_tvalid;
    logic [NPORTS-1:0]        m_tlast;
    logic [NPORTS-1:0]        m_tready;

    // The crossbar itself.
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    // Whatever drives ingress and consumes egress.
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/router_rr_arb.sv
// Per-output round-robin arbiter: IDLE/BUSY FSM holding a one-hot grant until the packet's tlast is taken.
module router_rr_arb
    import router_pkg::*;
#(
    parameter int NPORTS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPORTS-1:0] req,
    input  logic              rel,
    output logic [NPORTS-1:0] grant
);

    localparam int IDX_W = idx_w(NPORTS);

    state_e            state_q, state_d;
    logic [NPORTS-1:0] grant_q, grant_d;
    logic [NPORTS-1:0] pick;
    logic              found;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    // First pass covers [ptr, NPORTS), second pass wraps to [0, ptr).
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && req[i] && (i >= int'(ptr_q))) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && req[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    grant_d = '0;
                    state_d = IDLE;
                    for (int i = 0; i < NPORTS; i++) begin
                        if (grant_q[i]) begin
                            ptr_d = (i == NPORTS - 1) ? '0 : IDX_W'(i + 1);
                        end
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: rtl/router_xbar.sv
// NPORTS x NPORTS packet crossbar: header-routed, round-robin per output, whole-packet grants.
// Optional drop counter enabled by defining ROUTER_XBAR_DROP_CNT_EN.
module router_xbar
    import router_pkg::*;
#(
    parameter int NPORTS   = 3,
    parameter int DATA_W   = 64,
    parameter int DEST_LSB = 10,
    parameter int DEST_W   = 2
) (
    input logic          clk,
    input logic          rst_n,
    router_xbar_if.slave bus
`ifdef ROUTER_XBAR_DROP_CNT_EN
    ,
    output logic [15:0]  drop_cnt
`endif
);

    state_e                   in_state_q [NPORTS];
    state_e                   in_state_d [NPORTS];
    logic [DEST_W-1:0]        dest_q     [NPORTS];
    logic [DEST_W-1:0]        dest_d     [NPORTS];
    logic [DEST_W-1:0]        hdr_dest   [NPORTS];
    logic [DEST_W-1:0]        cur_dest   [NPORTS];
    logic [NPORTS-1:0]        req_to_out [NPORTS];
    logic [NPORTS-1:0]        grant      [NPORTS];
    logic [NPORTS-1:0]        hdr_ok;
    logic [NPORTS-1:0]        route_req;
    logic [NPORTS-1:0]        drop_now;
    logic [NPORTS-1:0]        last_acc;
    logic [NPORTS-1:0]        rel;
    logic [NPORTS-1:0]        m_tvalid_c;
    logic [NPORTS-1:0]        m_tlast_c;
    logic [NPORTS-1:0]        s_tready_c;
    logic [NPORTS*DATA_W-1:0] m_tdata_c;

    // Header decode: an input still expecting a header routes by the live beat, otherwise by its latched dest.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            hdr_dest[i]  = bus.s_tdata[i*DATA_W + DEST_LSB +: DEST_W];
            hdr_ok[i]    = (32'(hdr_dest[i]) < NPORTS);
            cur_dest[i]  = (in_state_q[i] == IDLE) ? hdr_dest[i] : dest_q[i];
            route_req[i] = (in_state_q[i] == BUSY) ||
                           ((in_state_q[i] == IDLE) && bus.s_tvalid[i] && hdr_ok[i]);
            drop_now[i]  = rst_n && (in_state_q[i] == IDLE) && bus.s_tvalid[i] && !hdr_ok[i];
        end
        for (int o = 0; o < NPORTS; o++) begin
            req_to_out[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                req_to_out[o][i] = route_req[i] && (32'(cur_dest[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_out
        router_rr_arb #(
            .NPORTS (NPORTS)
        ) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req_to_out[o]),
            .rel   (rel[o]),
            .grant (grant[o])
        );
    end

    // Data path is purely combinational from the registered grants.
    always_comb begin
        m_tdata_c  = '0;
        m_tvalid_c = '0;
        m_tlast_c  = '0;
        s_tready_c = '0;
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (grant[o][i]) begin
                    m_tdata_c[o*DATA_W +: DATA_W] = bus.s_tdata[i*DATA_W +: DATA_W];
                    m_tvalid_c[o]                 = bus.s_tvalid[i];
                    m_tlast_c[o]                  = bus.s_tlast[i];
                    s_tready_c[i]                 = s_tready_c[i] | bus.m_tready[o];
                end
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            s_tready_c[i] = rst_n && (s_tready_c[i] || drop_now[i] || (in_state_q[i] == DROP));
        end
    end

    assign rel          = m_tvalid_c & bus.m_tready & m_tlast_c;
    assign last_acc     = bus.s_tvalid & s_tready_c & bus.s_tlast;
    assign bus.m_tdata  = m_tdata_c;
    assign bus.m_tvalid = m_tvalid_c;
    assign bus.m_tlast  = m_tlast_c;
    assign bus.s_tready = s_tready_c;

    // A dropped single-beat packet never leaves IDLE; longer ones sink the rest of the packet in DROP.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            in_state_d[i] = in_state_q[i];
            dest_d[i]     = dest_q[i];
            case (in_state_q[i])
                IDLE: begin
                    if (bus.s_tvalid[i]) begin
                        if (hdr_ok[i]) begin
                            in_state_d[i] = BUSY;
                            dest_d[i]     = hdr_dest[i];
                        end else if (!bus.s_tlast[i]) begin
                            in_state_d[i] = DROP;
                        end
                    end
                end
                BUSY, DROP: begin
                    if (last_acc[i]) begin
                        in_state_d[i] = IDLE;
                    end
                end
                default: in_state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q <= '{default: IDLE};
            dest_q     <= '{default: '0};
        end else begin
            in_state_q <= in_state_d;
            dest_q     <= dest_d;
        end
    end

`ifdef ROUTER_XBAR_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NPORTS; i++) begin
            drop_sum = drop_sum + 17'(drop_now[i]);
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/router_xbar.md
ROUTER_XBAR -- requirements
Module: router_xbar

Interface
REQ-001 SHALL have parameter NPORTS, default 3, number of stream ports (0 local buffer, 1 left, 2 right).
REQ-002 SHALL have parameter DATA_W, default 64, stream data width.
REQ-003 SHALL have parameter DEST_LSB, default 10, bit position of the destination-port field in the header beat.
REQ-004 SHALL have parameter DEST_W, default 2, width of the destination-port field.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port s_tdata  input  NPORTS*DATA_W  ingress data, port i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have ports s_tvalid, s_tlast  input  NPORTS, and s_tready  output  NPORTS  ingress handshake, bit i = port i.
REQ-009 SHALL have port m_tdata  output  NPORTS*DATA_W  egress data, same packing.
REQ-010 SHALL have ports m_tvalid, m_tlast  output  NPORTS, and m_tready  input  NPORTS  egress handshake.

Function
REQ-011 SHALL treat the first beat after reset or after an accepted tlast on an input as the header; dest = header[DEST_LSB +: DEST_W].
REQ-012 SHALL have an input raise a request to output dest while s_tvalid is high at the header beat and keep it until its tlast beat is accepted.
REQ-013 SHALL run one FSM per output: IDLE (no grant) and BUSY (grant held by one input).
REQ-014 SHALL in IDLE, with at least one request, register a grant to the first requester found searching upward (modulo NPORTS) from the round-robin pointer, entering BUSY the next cycle; the arbitration cycle moves no data.
REQ-015 SHALL in BUSY drive m_tdata/m_tvalid/m_tlast from the granted input and s_tready of that input from m_tready, combinationally with zero added latency.
REQ-016 SHALL, on the accepted tlast beat (m_tvalid & m_tready & m_tlast), return to IDLE and set the pointer to granted index + 1 modulo NPORTS.
REQ-017 SHALL re-arbitrate only in the cycle after release, giving exactly one idle cycle between back-to-back packets on one output.
REQ-018 SHALL keep the whole packet on one output: no interleaving and no grant change mid-packet, regardless of m_tready stalls.
REQ-019 SHALL hold s_tready low for an input with a header pending but not granted; data SHALL NOT be lost or duplicated.
REQ-020 SHALL allow dest equal to the input's own index (loopback).
REQ-021 SHALL drop packets with dest >= NPORTS: that input enters DROP, s_tready=1 until its tlast beat is accepted, and nothing is forwarded.
REQ-022 SHALL drive m_tdata to zero and m_tvalid/m_tlast low on an IDLE output.
REQ-023 SHALL let different outputs serve different inputs in the same cycle (full crossbar concurrency).

Reset
REQ-024 SHALL on rst_n low, at any time including mid-packet: set all outputs IDLE, clear grants, set all pointers to 0, return all inputs to header-expected, and drive m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0.
REQ-025 SHALL NOT resume a partial packet after reset; the next beat on each input is a header.

Configuration
REQ-026 SHALL, with ROUTER_XBAR_DROP_CNT_EN defined, add output drop_cnt [15:0], reset 0, which increments on each dropped header beat and saturates at 16'hFFFF.
REQ-027 SHALL, without ROUTER_XBAR_DROP_CNT_EN, omit drop_cnt and its logic; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the FSM state encodings (IDLE, BUSY, DROP) and the port-index constants (LOCAL=0, LEFT=1, RIGHT=2) in shared package router_pkg.
REQ-029 SHALL implement per-output arbitration as sub-module router_rr_arb (NPORTS-bit request in, one-hot grant out, pointer update on release), instantiated NPORTS times.

Verification
REQ-030 SHALL cover: port1 sends a 4-beat packet, dest=2, m_tready=1 -> port2 shows the 4 beats in order starting 1 cycle after the header is valid, with m_tlast on beat 4.
REQ-031 SHALL cover: ports 0, 1 and 2 all send 2-beat packets to dest=0 simultaneously after reset -> grant order 0, 1, 2 with one idle cycle between packets.
REQ-032 SHALL cover: port0 to dest=1 and port2 to dest=0 concurrently -> both outputs active in the same cycles, data intact.
REQ-033 SHALL cover: m_tready toggling 1,0,0,1 during a 3-beat packet -> data held stable while stalled and no other input granted mid-packet.
REQ-034 SHALL cover: a header with dest=3 on port1 (NPORTS=3), 5 beats -> all 5 accepted, no m_tvalid on any output, and drop_cnt=1 when the macro is defined.
REQ-035 SHALL cover: rst_n asserted on beat 2 of a 4-beat packet -> all m_tvalid low immediately, and the next beat is treated as a header and routed by its own dest.
